fifo_wr_arbiter: RTL

Round-robin write arbiter that shares the write port of one `f_i_f_o` instance between N independent producers. Each producer raises a request with data. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `wr_en`/`din`. It honours the FIFO `full` flag so that no beat is ever dropped or duplicated. It sits directly in front of the FIFO write side; the read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM state (IDLE = no grant, HOLD = one owner granted)
//   DEF_*       : default data width, requester count and burst length
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  localparam int DEF_X     = 4;
  localparam int DEF_N     = 4;
  localparam int DEF_BURST = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: returns the first asserted request scanning
// ptr, ptr+1, ..., N-1, 0, ..., ptr-1. Purely combinational.
//   req   : per-requester request bits
//   ptr   : highest-priority index for this scan
//   valid : at least one request is asserted
//   idx   : index of the winning requester (0 when !valid)
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N  = DEF_N,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);

  int j;

  // Scan from the far end back toward ptr so the closest hit is the last
  // assignment and therefore wins, avoiding a separate "found" flag.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[PW'(j)]) begin
        valid = 1'b1;
        idx   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port between N producers.
// A grant lasts until the owner drops its request or BURST beats are written;
// a full FIFO stalls the grant without dropping or duplicating beats.
//   clk, rst   : clock, synchronous active-high reset
//   req        : per-requester request
//   req_data   : flattened data, requester i at [i*X +: X]
//   gnt        : one-hot grant decoded from registered owner, 0 when idle
//   ack        : one-hot, requester's beat is written this cycle
//   fifo_wr_en : FIFO write enable
//   fifo_din   : FIFO write data
//   fifo_full  : FIFO full flag
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int X     = DEF_X,
  parameter int N     = DEF_N,
  parameter int BURST = DEF_BURST
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*X-1:0] req_data,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic           fifo_wr_en,
  output logic [X-1:0]   fifo_din,
  input  logic           fifo_full
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(BURST + 1);

  arb_state_t    state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] beat_q, beat_d;

  logic          holding;
  logic          wr_ok;
  logic          release_c;
  logic [PW-1:0] owner_inc;
  logic [PW-1:0] pick_ptr;
  logic          pick_valid;
  logic [PW-1:0] pick_idx;

  assign holding   = (state_q == HOLD);
  assign wr_ok     = holding & req[owner_q] & ~fifo_full;
  assign release_c = holding & (~req[owner_q] | (wr_ok & (beat_q == CW'(BURST - 1))));
  assign owner_inc = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;
  // On release the scan already starts past the old owner, so a handover
  // happens in the same cycle without an idle bubble.
  assign pick_ptr  = release_c ? owner_inc : ptr_q;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = HOLD;
          owner_d = pick_idx;
          beat_d  = '0;
        end
      end
      HOLD: begin
        if (release_c) begin
          ptr_d = owner_inc;
          if (pick_valid) begin
            owner_d = pick_idx;
            beat_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (wr_ok) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt        = '0;
    ack        = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    if (holding) begin
      gnt[owner_q] = 1'b1;
      fifo_din     = req_data[int'(owner_q)*X +: X];
      // Reset kills the write immediately rather than waiting for the edge.
      if (wr_ok && !rst) begin
        fifo_wr_en   = 1'b1;
        ack[owner_q] = 1'b1;
      end
    end
  end

endmodule
